// File: rtl/spi_status_ctrl.sv
// APB status/interrupt block for the SPI peripheral: FIFO flags, sticky W1C IRQ flags, mask, watermarks.
// Optional RX overrun error counter at 0x10 is enabled by defining SPI_STAT_ERRCNT_EN.
module spi_status_ctrl #(
  parameter int DEPTH = 8,
  parameter int LVL_W = 4
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             PSEL,
  input  logic             PENABLE,
  input  logic             PWRITE,
  input  logic [4:0]       PADDR,
  input  logic [31:0]      PWDATA,
  output logic [31:0]      PRDATA,
  output logic             PREADY,
  input  logic [LVL_W-1:0] TX_LEVEL,
  input  logic [LVL_W-1:0] RX_LEVEL,
  input  logic             TX_UNDERRUN,
  input  logic             RX_OVERRUN,
  input  logic             BUSY,
  output logic             TXFIFO_FULL,
  output logic             TXFIFO_EMPTY,
  output logic             RXFIFO_FULL,
  output logic             RXFIFO_EMPTY,
  output logic             IRQ
);

  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] WM_RST  = LVL_W'(DEPTH / 2);

  logic             tx_full_q, tx_full_d, tx_empty_q, tx_empty_d;
  logic             rx_full_q, rx_full_d, rx_empty_q, rx_empty_d;
  logic [LVL_W-1:0] tx_lvl_q, tx_lvl_d, rx_lvl_q, rx_lvl_d;
  logic             busy_q, busy_d;
  logic [LVL_W-1:0] tx_wm_q, tx_wm_d, rx_wm_q, rx_wm_d;
  logic             txwm_c_q, txwm_c_d, rxwm_c_q, rxwm_c_d;
  logic [4:0]       stat_q, stat_d, mask_q, mask_d;
  logic             irq_q, irq_d;
  logic [31:0]      prdata_q, prdata_d;
`ifdef SPI_STAT_ERRCNT_EN
  logic [7:0]       errcnt_q, errcnt_d;
`endif

  logic             wr_s, rd_setup_s, wm_wr_s;
  logic [2:0]       addr_s;
  logic [4:0]       set_s, clr_s;
  logic [31:0]      rdata_s;
  logic             unused_s;

  assign unused_s = ^{PWDATA, PADDR[1:0]};
  assign PREADY   = 1'b1;

  // Next-state logic for flags, sticky interrupt state, APB registers and read data.
  always_comb begin
    wr_s       = PSEL & PENABLE & PWRITE;
    rd_setup_s = PSEL & ~PENABLE & ~PWRITE;
    addr_s     = PADDR[4:2];
    wm_wr_s    = wr_s && (addr_s == 3'd3);

    tx_full_d  = (TX_LEVEL >= DEPTH_L);
    tx_empty_d = (TX_LEVEL == {LVL_W{1'b0}});
    rx_full_d  = (RX_LEVEL >= DEPTH_L);
    rx_empty_d = (RX_LEVEL == {LVL_W{1'b0}});
    tx_lvl_d   = TX_LEVEL;
    rx_lvl_d   = RX_LEVEL;
    busy_d     = BUSY;

    mask_d  = mask_q;
    tx_wm_d = tx_wm_q;
    rx_wm_d = rx_wm_q;
    if (wr_s && (addr_s == 3'd2)) begin
      mask_d = PWDATA[4:0];
    end else begin
      mask_d = mask_q;
    end
    if (wm_wr_s) begin
      tx_wm_d = PWDATA[LVL_W-1:0];
      rx_wm_d = PWDATA[8 +: LVL_W];
    end else begin
      tx_wm_d = tx_wm_q;
      rx_wm_d = rx_wm_q;
    end

    // Conditions track the threshold in force after this edge, so a threshold write never looks like an edge.
    txwm_c_d = (TX_LEVEL <= tx_wm_d);
    rxwm_c_d = (RX_LEVEL >= rx_wm_d);

    set_s = {busy_q & ~BUSY,
             rxwm_c_d & ~rxwm_c_q & ~wm_wr_s,
             txwm_c_d & ~txwm_c_q & ~wm_wr_s,
             RX_OVERRUN,
             TX_UNDERRUN};
    if (wr_s && (addr_s == 3'd1)) begin
      clr_s = PWDATA[4:0];
    end else begin
      clr_s = 5'd0;
    end
    stat_d = (stat_q & ~clr_s) | set_s;
    irq_d  = |(stat_q & mask_q);

`ifdef SPI_STAT_ERRCNT_EN
    errcnt_d = errcnt_q;
    if (wr_s && (addr_s == 3'd4)) begin
      errcnt_d = RX_OVERRUN ? 8'd1 : 8'd0;
    end else if (RX_OVERRUN && (errcnt_q != 8'd255)) begin
      errcnt_d = errcnt_q + 8'd1;
    end else begin
      errcnt_d = errcnt_q;
    end
`endif

    rdata_s = 32'd0;
    case (addr_s)
      3'd0: begin
        rdata_s[0]     = tx_full_q;
        rdata_s[1]     = tx_empty_q;
        rdata_s[2]     = rx_full_q;
        rdata_s[3]     = rx_empty_q;
        rdata_s[4]     = busy_q;
        rdata_s[15:8]  = 8'(tx_lvl_q);
        rdata_s[23:16] = 8'(rx_lvl_q);
      end
      3'd1: rdata_s[4:0] = stat_q;
      3'd2: rdata_s[4:0] = mask_q;
      3'd3: begin
        rdata_s[7:0]  = 8'(tx_wm_q);
        rdata_s[15:8] = 8'(rx_wm_q);
      end
`ifdef SPI_STAT_ERRCNT_EN
      3'd4: rdata_s[7:0] = errcnt_q;
`endif
      default: rdata_s = 32'd0;
    endcase

    if (rd_setup_s) begin
      prdata_d = rdata_s;
    end else if (PSEL) begin
      prdata_d = prdata_q;
    end else begin
      prdata_d = 32'd0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tx_full_q  <= 1'b0;
      tx_empty_q <= 1'b1;
      rx_full_q  <= 1'b0;
      rx_empty_q <= 1'b1;
      tx_lvl_q   <= {LVL_W{1'b0}};
      rx_lvl_q   <= {LVL_W{1'b0}};
      busy_q     <= 1'b0;
      tx_wm_q    <= WM_RST;
      rx_wm_q    <= WM_RST;
      txwm_c_q   <= 1'b0;
      rxwm_c_q   <= 1'b0;
      stat_q     <= 5'd0;
      mask_q     <= 5'd0;
      irq_q      <= 1'b0;
      prdata_q   <= 32'd0;
`ifdef SPI_STAT_ERRCNT_EN
      errcnt_q   <= 8'd0;
`endif
    end else begin
      tx_full_q  <= tx_full_d;
      tx_empty_q <= tx_empty_d;
      rx_full_q  <= rx_full_d;
      rx_empty_q <= rx_empty_d;
      tx_lvl_q   <= tx_lvl_d;
      rx_lvl_q   <= rx_lvl_d;
      busy_q     <= busy_d;
      tx_wm_q    <= tx_wm_d;
      rx_wm_q    <= rx_wm_d;
      txwm_c_q   <= txwm_c_d;
      rxwm_c_q   <= rxwm_c_d;
      stat_q     <= stat_d;
      mask_q     <= mask_d;
      irq_q      <= irq_d;
      prdata_q   <= prdata_d;
`ifdef SPI_STAT_ERRCNT_EN
      errcnt_q   <= errcnt_d;
`endif
    end
  end

  assign TXFIFO_FULL  = tx_full_q;
  assign TXFIFO_EMPTY = tx_empty_q;
  assign RXFIFO_FULL  = rx_full_q;
  assign RXFIFO_EMPTY = rx_empty_q;
  assign IRQ          = irq_q;
  assign PRDATA       = prdata_q;

endmodule
